// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide data types.
package cpu_types_pkg;
    localparam int unsigned WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_stage_pkg.sv
// Types and helpers for the memory-stage access controller.
package mem_stage_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } mem_stage_state_t;

    // Counter width able to hold the value `timeout` itself.
    function automatic int unsigned tmo_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Bundle of the memory-stage controller's connections to cache, hazard unit and pipeline regs.
interface mem_stage_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import cpu_types_pkg::*;

    logic             pipe_en;
    logic             dREN_EX_MEM;
    logic             dWEN_EX_MEM;
    logic             halt_EX_MEM;
    word_t            result_EX_MEM;
    word_t            store_data_EX_MEM;
    logic             dhit;
    word_t            dmemload;
    logic             dmemREN;
    logic             dmemWEN;
    word_t            dmemaddr;
    word_t            dmemstore;
    word_t            dmemload_MEM;
    logic             enable_MEM_WB;
    logic             flush_MEM_WB;
    logic             stall_MEM;
    logic             halt;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport msc (
        input  pipe_en, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, result_EX_MEM,
               store_data_EX_MEM, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload_MEM, enable_MEM_WB,
               flush_MEM_WB, stall_MEM, halt, mem_err, stall_cycles
    );

    modport cache (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );

    modport hazard (
        input  stall_MEM, halt,
        output pipe_en
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues D-cache requests for the EX/MEM instruction, stalls on
// misses, buffers load data while the pipeline is frozen and retires halt.
module mem_stage_ctrl
    import cpu_types_pkg::*;
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             pipe_en,
    input  logic             dREN_EX_MEM,
    input  logic             dWEN_EX_MEM,
    input  logic             halt_EX_MEM,
    input  word_t            result_EX_MEM,
    input  word_t            store_data_EX_MEM,
    input  logic             dhit,
    input  word_t            dmemload,
    output logic             dmemREN,
    output logic             dmemWEN,
    output word_t            dmemaddr,
    output word_t            dmemstore,
    output word_t            dmemload_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_MEM_WB,
    output logic             stall_MEM,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int unsigned TMO_W = tmo_width(TIMEOUT);

    mem_stage_state_t state_q, state_d;
    word_t            buf_q, buf_d;
    logic             mem_err_q, mem_err_d;
    logic [TMO_W-1:0] tmo_cnt;

    logic  mop, req_on, en_mwb, stall;
    word_t load_mem;

    // A halting instruction never issues a request.
    assign mop = (dREN_EX_MEM | dWEN_EX_MEM) & ~halt_EX_MEM;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        mem_err_d = mem_err_q;
        req_on    = 1'b0;
        en_mwb    = 1'b0;
        stall     = 1'b0;
        load_mem  = '0;

        unique case (state_q)
            IDLE, ACCESS: begin
                if ((state_q == IDLE) && halt_EX_MEM) begin
                    en_mwb = pipe_en;
                    if (pipe_en) state_d = HALTED;
                end else if (mop) begin
                    req_on = 1'b1;
                    if (dhit) begin
                        if (pipe_en) begin
                            en_mwb   = 1'b1;
                            load_mem = dmemload;
                            state_d  = IDLE;
                        end else begin
                            buf_d   = dmemload;
                            state_d = DONE;
                        end
                    end else begin
                        stall   = 1'b1;
                        state_d = ACCESS;
                    end
                end else begin
                    en_mwb  = pipe_en;
                    state_d = IDLE;
                end
            end
            DONE: begin
                load_mem = buf_q;
                if (pipe_en) begin
                    en_mwb  = 1'b1;
                    state_d = IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = IDLE;
        endcase

        if (req_on && dREN_EX_MEM && dWEN_EX_MEM) mem_err_d = 1'b1;
        // Count reads TIMEOUT-1 during the TIMEOUT-th ACCESS cycle.
        if ((state_q == ACCESS) && (tmo_cnt >= TMO_W'(TIMEOUT - 1))) mem_err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            mem_err_q <= mem_err_d;
        end
    end

    sat_counter #(
        .W (TMO_W)
    ) u_tmo_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (state_q == ACCESS),
        .clr   (state_q != ACCESS),
        .count (tmo_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (stall),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    // Reset gates the control outputs so an in-flight request drops immediately.
    assign dmemREN       = req_on & ~dWEN_EX_MEM & nRST;
    assign dmemWEN       = req_on & dWEN_EX_MEM & nRST;
    assign dmemaddr      = result_EX_MEM;
    assign dmemstore     = store_data_EX_MEM;
    assign dmemload_MEM  = nRST ? load_mem : '0;
    assign enable_MEM_WB = en_mwb & nRST;
    assign stall_MEM     = stall & nRST;
    assign flush_MEM_WB  = stall & nRST;
    assign halt          = (state_q == HALTED);
    assign mem_err       = mem_err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed and randomized transaction-level bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;
    import cpu_types_pkg::*;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 6;
    localparam int MAX_CNT    = (1 << TB_CNT_W) - 1;

    logic                CLK = 1'b0;
    logic                nRST;
    logic                pipe_en, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, dhit;
    word_t               result_EX_MEM, store_data_EX_MEM, dmemload;
    logic                dmemREN, dmemWEN, enable_MEM_WB, flush_MEM_WB, stall_MEM, halt, mem_err;
    word_t               dmemaddr, dmemstore, dmemload_MEM;
    logic [TB_CNT_W-1:0] stall_cycles;

    int   checks = 0;
    int   errors = 0;
    int   exp_stalls;
    logic exp_err;

    always #5 CLK = ~CLK;

    mem_stage_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .pipe_en           (pipe_en),
        .dREN_EX_MEM       (dREN_EX_MEM),
        .dWEN_EX_MEM       (dWEN_EX_MEM),
        .halt_EX_MEM       (halt_EX_MEM),
        .result_EX_MEM     (result_EX_MEM),
        .store_data_EX_MEM (store_data_EX_MEM),
        .dhit              (dhit),
        .dmemload          (dmemload),
        .dmemREN           (dmemREN),
        .dmemWEN           (dmemWEN),
        .dmemaddr          (dmemaddr),
        .dmemstore         (dmemstore),
        .dmemload_MEM      (dmemload_MEM),
        .enable_MEM_WB     (enable_MEM_WB),
        .flush_MEM_WB      (flush_MEM_WB),
        .stall_MEM         (stall_MEM),
        .halt              (halt),
        .mem_err           (mem_err),
        .stall_cycles      (stall_cycles)
    );

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_status();
        check_w("stall_cycles", 32'(stall_cycles), 32'(exp_stalls));
        check_b("mem_err", mem_err, exp_err);
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        #2;
        check_b("rst_ren", dmemREN, 1'b0);
        check_b("rst_wen", dmemWEN, 1'b0);
        check_b("rst_en", enable_MEM_WB, 1'b0);
        check_b("rst_flush", flush_MEM_WB, 1'b0);
        check_b("rst_stall", stall_MEM, 1'b0);
        check_b("rst_halt", halt, 1'b0);
        check_b("rst_err", mem_err, 1'b0);
        check_w("rst_load", dmemload_MEM, 32'h0);
        check_w("rst_stallcnt", 32'(stall_cycles), 32'h0);
        {dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, pipe_en, dhit} = 5'b0;
        nRST       = 1'b1;
        exp_stalls = 0;
        exp_err    = 1'b0;
        tick();
    endtask

    // One EX/MEM instruction: lat miss cycles, hit with pen_hit, then frz frozen cycles if held.
    task automatic do_txn(input logic ren, input logic wen, input word_t addr, input word_t sdata,
                          input word_t ldata, input int lat, input logic pen_hit, input int frz);
        logic mop;
        logic exp_ren;
        mop               = ren | wen;
        exp_ren           = ren & ~wen;
        dREN_EX_MEM       = ren;
        dWEN_EX_MEM       = wen;
        halt_EX_MEM       = 1'b0;
        result_EX_MEM     = addr;
        store_data_EX_MEM = sdata;
        if (!mop) begin
            pipe_en  = pen_hit;
            dhit     = 1'($urandom_range(0, 1));
            dmemload = ldata;
            #2;
            check_b("nop_en", enable_MEM_WB, pen_hit);
            check_b("nop_stall", stall_MEM, 1'b0);
            check_b("nop_ren", dmemREN, 1'b0);
            check_b("nop_wen", dmemWEN, 1'b0);
            check_w("nop_load", dmemload_MEM, 32'h0);
            tick();
            check_status();
            return;
        end
        for (int i = 0; i < lat; i++) begin
            pipe_en  = 1'($urandom_range(0, 1));
            dhit     = 1'b0;
            dmemload = word_t'($urandom);
            #2;
            check_b("miss_stall", stall_MEM, 1'b1);
            check_b("miss_flush", flush_MEM_WB, 1'b1);
            check_b("miss_en", enable_MEM_WB, 1'b0);
            check_b("miss_ren", dmemREN, exp_ren);
            check_b("miss_wen", dmemWEN, wen);
            check_w("miss_addr", dmemaddr, addr);
            check_w("miss_store", dmemstore, sdata);
            tick();
        end
        pipe_en  = pen_hit;
        dhit     = 1'b1;
        dmemload = ldata;
        #2;
        check_b("hit_ren", dmemREN, exp_ren);
        check_b("hit_wen", dmemWEN, wen);
        check_b("hit_stall", stall_MEM, 1'b0);
        check_b("hit_flush", flush_MEM_WB, 1'b0);
        check_b("hit_en", enable_MEM_WB, pen_hit);
        if (pen_hit) check_w("hit_load", dmemload_MEM, ldata);
        tick();
        if (!pen_hit) begin
            for (int j = 0; j < frz; j++) begin
                pipe_en  = 1'b0;
                dhit     = 1'($urandom_range(0, 1));
                dmemload = word_t'($urandom);
                #2;
                check_b("frz_ren", dmemREN, 1'b0);
                check_b("frz_wen", dmemWEN, 1'b0);
                check_b("frz_en", enable_MEM_WB, 1'b0);
                check_b("frz_stall", stall_MEM, 1'b0);
                check_w("frz_load", dmemload_MEM, ldata);
                tick();
            end
            pipe_en = 1'b1;
            dhit    = 1'($urandom_range(0, 1));
            #2;
            check_b("rel_en", enable_MEM_WB, 1'b1);
            check_b("rel_ren", dmemREN, 1'b0);
            check_b("rel_wen", dmemWEN, 1'b0);
            check_w("rel_load", dmemload_MEM, ldata);
            tick();
        end
        exp_stalls = (exp_stalls + lat > MAX_CNT) ? MAX_CNT : exp_stalls + lat;
        if ((ren && wen) || (lat >= TB_TIMEOUT)) exp_err = 1'b1;
        check_status();
    endtask

    initial begin
        nRST              = 1'b0;
        {pipe_en, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, dhit} = 5'b0;
        result_EX_MEM     = '0;
        store_data_EX_MEM = '0;
        dmemload          = '0;
        exp_stalls        = 0;
        exp_err           = 1'b0;
        apply_reset();

        // Zero-wait load hit.
        do_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 0);

        // Three-cycle store miss from a clean counter.
        apply_reset();
        do_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0000_1234, 32'h0, 3, 1'b1, 0);
        check_w("store_miss_cnt", 32'(stall_cycles), 32'd3);

        // Completion while frozen, held for four cycles.
        do_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_0001, 0, 1'b0, 4);

        for (int t = 0; t < 30; t++) begin
            int   kind;
            logic r, w;
            kind = $urandom_range(0, 7);
            r    = (kind == 1) || (kind == 2) || (kind == 3) || (kind == 7);
            w    = (kind == 4) || (kind == 5) || (kind == 6) || (kind == 7);
            do_txn(r, w, word_t'($urandom), word_t'($urandom), word_t'($urandom),
                   $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Long miss saturates the stall counter and trips the timeout.
        apply_reset();
        do_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 70, 1'b1, 0);

        // Timeout: mem_err after exactly TB_TIMEOUT ACCESS cycles, FSM keeps waiting.
        apply_reset();
        dREN_EX_MEM = 1'b1;
        pipe_en     = 1'b0;
        dhit        = 1'b0;
        tick();
        for (int k = 0; k < TB_TIMEOUT - 1; k++) tick();
        check_b("tmo_before", mem_err, 1'b0);
        tick();
        check_b("tmo_after", mem_err, 1'b1);
        check_b("tmo_wait", stall_MEM, 1'b1);
        dhit    = 1'b1;
        pipe_en = 1'b1;
        #2;
        check_b("tmo_done_en", enable_MEM_WB, 1'b1);
        tick();

        // Illegal read+write issues a write only.
        apply_reset();
        do_txn(1'b1, 1'b1, 32'h0000_0400, 32'h0000_00AB, 32'h0, 0, 1'b1, 0);
        check_b("illegal_err", mem_err, 1'b1);

        // Reset in the middle of a miss.
        apply_reset();
        dREN_EX_MEM   = 1'b1;
        result_EX_MEM = 32'h0000_0500;
        pipe_en       = 1'b1;
        dhit          = 1'b0;
        tick();
        #1;
        check_b("mid_stall_pre", stall_MEM, 1'b1);
        nRST = 1'b0;
        #1;
        check_b("mid_ren", dmemREN, 1'b0);
        check_b("mid_stall", stall_MEM, 1'b0);
        check_b("mid_flush", flush_MEM_WB, 1'b0);
        check_b("mid_en", enable_MEM_WB, 1'b0);
        check_w("mid_cnt", 32'(stall_cycles), 32'h0);
        dREN_EX_MEM = 1'b0;
        nRST        = 1'b1;
        tick();
        #2;
        check_b("mid_idle_en", enable_MEM_WB, 1'b1);
        check_b("mid_idle_stall", stall_MEM, 1'b0);
        check_w("mid_idle_cnt", 32'(stall_cycles), 32'h0);
        tick();

        // Halt wins over a simultaneous request, then sticks.
        halt_EX_MEM = 1'b1;
        dREN_EX_MEM = 1'b1;
        pipe_en     = 1'b1;
        #2;
        check_b("halt_en", enable_MEM_WB, 1'b1);
        check_b("halt_noreq", dmemREN, 1'b0);
        check_b("halt_pre", halt, 1'b0);
        tick();
        halt_EX_MEM = 1'b0;
        for (int h = 0; h < 4; h++) begin
            pipe_en = 1'($urandom_range(0, 1));
            dhit    = 1'($urandom_range(0, 1));
            #2;
            check_b("halted_halt", halt, 1'b1);
            check_b("halted_ren", dmemREN, 1'b0);
            check_b("halted_en", enable_MEM_WB, 1'b0);
            check_b("halted_stall", stall_MEM, 1'b0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

- Memory-stage access controller of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- It issues data-cache read/write requests for the instruction held in EX/MEM and waits on `dhit`. If the pipeline is frozen when the hit arrives, it buffers the load data.
- It drives `enable_MEM_WB` / `flush_MEM_WB`, raises `stall_MEM` to the hazard unit, and handles `halt` retirement.

## Interface
- `TIMEOUT`, 1024: ACCESS-state cycles before `mem_err` sets.
- `CNT_W`, 32: width of the saturating stall-cycle counter.
- `CLK  in  1`: single clock, rising edge.
- `nRST  in  1`: asynchronous, active-low reset.
- `pipe_en  in  1`: global advance from the hazard unit (fetch not stalled).
- `dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM  in  1 each`: EX/MEM control.
- `result_EX_MEM  in  word_t`: ALU result, used as the data address.
- `store_data_EX_MEM  in  word_t`: rt value for stores.
- `dhit  in  1`: cache completion.
- `dmemload  in  word_t`: cache read data.
- `dmemREN, dmemWEN  out  1`: cache requests.
- `dmemaddr, dmemstore  out  word_t`: request address and store data.
- `dmemload_MEM  out  word_t`: load data to MEM/WB (the `dmemload` port of MEM/WB).
- `enable_MEM_WB, flush_MEM_WB  out  1`: MEM/WB register control.
- `stall_MEM  out  1`: MEM-stage busy; hazard unit freezes IF–EX/MEM.
- `halt  out  1`: sticky processor halt.
- `mem_err  out  1`: sticky timeout or illegal-request flag.
- `stall_cycles  out  CNT_W`: count of cycles with `stall_MEM=1`.

## Operation
- Memory op: `mop = dREN_EX_MEM | dWEN_EX_MEM`.
- If `dREN_EX_MEM` and `dWEN_EX_MEM` are both 1, the request is issued as a write only and `mem_err` sets.
- `dmemaddr = result_EX_MEM`; `dmemstore = store_data_EX_MEM`.
- FSM states: IDLE, ACCESS, DONE, HALTED.
- IDLE:
  - Requests are driven combinationally when `mop` is set, so a zero-wait hit is possible.
  - `mop & dhit & pipe_en`: `enable_MEM_WB=1`, `dmemload_MEM=dmemload`, stay in IDLE.
  - `mop & dhit & ~pipe_en`: latch `dmemload` into the buffer, go to DONE.
  - `mop & ~dhit`: go to ACCESS.
  - No `mop`: `enable_MEM_WB=pipe_en`.
  - `halt_EX_MEM & pipe_en`: `enable_MEM_WB=1`, go to HALTED. Halt takes priority over any request; no request is issued for it.
- ACCESS:
  - Requests are held asserted and stable.
  - On `dhit`, the same `pipe_en` split as IDLE applies (to IDLE or DONE).
  - The cycle counter increments every cycle in ACCESS and clears on exit. Reaching `TIMEOUT` sets `mem_err`; the FSM keeps waiting.
- DONE:
  - Requests are 0 and `dmemload_MEM` = buffer.
  - On `pipe_en`: `enable_MEM_WB=1`, go to IDLE.
- HALTED:
  - Terminal until reset.
  - `halt=1`, requests 0, `enable_MEM_WB=0`, `stall_MEM=0`.
- `stall_MEM = mop & ~dhit` in IDLE or ACCESS; it is 0 in DONE and HALTED.
- `flush_MEM_WB = stall_MEM`, so a bubble (WEN cleared) enters WB while MEM waits.
- `stall_cycles` saturates at all-ones and never wraps.
- `dmemload_MEM` is 0 when no load is completing and the FSM is not in DONE.

## Timing
- Reset (`nRST=0`, asynchronous):
  - FSM to IDLE; buffer, timeout counter, `stall_cycles`, `halt`, `mem_err` all clear to 0.
  - All outputs that are not combinational from EX/MEM inputs are 0.
  - Reset during ACCESS abandons the request: requests drop in the same cycle.
- Hit latency: a zero-wait hit completes in the request cycle. An N-cycle miss gives N cycles of `stall_MEM` and N bubbles.
- Requests never change while in ACCESS.
- No request is reissued after DONE. When `pipe_en` advances EX/MEM, a new op appears in the following cycle.
- `dhit` in IDLE/ACCESS with no `mop` asserted is ignored.
- `pipe_en=0` with `dhit` arriving: data must survive any number of frozen cycles in DONE.

## Structure
- Add the `mem_stage_state_t` enum (IDLE, ACCESS, DONE, HALTED) to a new `mem_stage_pkg`; `word_t` comes from `cpu_types_pkg`.
- Provide interface `mem_stage_ctrl_if` with modports `msc` (this block), `cache`, `hazard`.
- One sub-module, `sat_counter` (parameter `W`; ports `en`, `clr`, `count`), used for both `stall_cycles` and the timeout counter.

## Test plan
- Load hit: `dREN=1`, addr `0x0000_0040`, `dhit=1` with `dmemload=0xDEAD_BEEF`, `pipe_en=1` → same cycle `dmemREN=1`, `enable_MEM_WB=1`, `dmemload_MEM=0xDEADBEEF`, `stall_MEM=0`.
- 3-cycle store miss: `dWEN=1`, data `0x1234`, `dhit` asserted on cycle 3 → `stall_MEM=flush_MEM_WB=1` for cycles 0–2; `dmemWEN` and `dmemstore` stable throughout; `stall_cycles=3`.
- Frozen completion: `dhit` arrives while `pipe_en=0`, load data `0xCAFE_0001`, then 4 frozen cycles → DONE with requests 0 and `dmemload_MEM=0xCAFE0001`. Raising `pipe_en` gives one `enable_MEM_WB` pulse and a return to IDLE.
- Halt: `halt_EX_MEM=1`, `pipe_en=1` → one `enable_MEM_WB` pulse; `halt=1` from the next cycle onward. Later `dREN` inputs produce no request.
- Timeout / illegal request: `TIMEOUT=8`, `dhit` held 0 → `mem_err=1` after 8 ACCESS cycles. After reset, `dREN=dWEN=1` → write issued only and `mem_err=1`.
- Mid-miss reset: drop `nRST` during ACCESS → all outputs 0 immediately; after release, IDLE with `stall_cycles=0`.
